// File: rtl/adam_lspa_apb_demux.sv
// ---------------------------------------------------------------------------
// adam_lspa_apb_demux
//
// APB target that accepts one upstream transfer and forwards it to one of
// NO_SLOTS downstream peripheral slots of an LSP window. The slot comes from
// the address: slot i covers [MMAP_START + i*MMAP_INC, MMAP_START + (i+1)*MMAP_INC).
// Addresses outside the window, and downstream transfers that stay unready for
// TIMEOUT access cycles, are answered with an error response.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_psel .. s_pstrb          upstream APB request (from the fabric bridge)
//   s_prdata/s_pready/s_pslverr upstream response, one-cycle pulse
//   m_psel[NO_SLOTS]           one-hot downstream select
//   m_penable .. m_pstrb       downstream request, shared by all slots;
//                              m_paddr carries the offset within the slot
//   m_prdata/m_pready/m_pslverr per-slot downstream response buses
//
// Every output is a flop. A zero-wait slot answers upstream three cycles after
// the SETUP cycle; a decode miss answers one cycle after it.
// ---------------------------------------------------------------------------
module adam_lspa_apb_demux #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NO_SLOTS   = 4,
  parameter logic [ADDR_WIDTH-1:0] MMAP_START = 'h0001_0000,
  parameter logic [ADDR_WIDTH-1:0] MMAP_INC   = 'h0000_0400,
  parameter int unsigned           TIMEOUT    = 255
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_psel,
  input  logic                           s_penable,
  input  logic                           s_pwrite,
  input  logic [ADDR_WIDTH-1:0]          s_paddr,
  input  logic [DATA_WIDTH-1:0]          s_pwdata,
  input  logic [DATA_WIDTH/8-1:0]        s_pstrb,
  output logic [DATA_WIDTH-1:0]          s_prdata,
  output logic                           s_pready,
  output logic                           s_pslverr,
  output logic [NO_SLOTS-1:0]            m_psel,
  output logic                           m_penable,
  output logic                           m_pwrite,
  output logic [ADDR_WIDTH-1:0]          m_paddr,
  output logic [DATA_WIDTH-1:0]          m_pwdata,
  output logic [DATA_WIDTH/8-1:0]        m_pstrb,
  input  logic [NO_SLOTS*DATA_WIDTH-1:0] m_prdata,
  input  logic [NO_SLOTS-1:0]            m_pready,
  input  logic [NO_SLOTS-1:0]            m_pslverr
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned SLOT_W   = (NO_SLOTS > 1) ? $clog2(NO_SLOTS) : 1;
  localparam int unsigned INC_LOG2 = $clog2(MMAP_INC);

  // Decode arithmetic carries one extra bit so a window ending exactly at
  // 2^ADDR_WIDTH does not wrap to zero.
  typedef logic [ADDR_WIDTH:0]   addr_x_t;
  typedef logic [SLOT_W-1:0]     slot_t;
  typedef logic [NO_SLOTS-1:0]   sel_t;

  localparam addr_x_t               START_X   = {1'b0, MMAP_START};
  localparam addr_x_t               SPAN_X    = addr_x_t'(NO_SLOTS) * {1'b0, MMAP_INC};
  localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = MMAP_INC - 1'b1;
  localparam logic [15:0]           TO_LAST   = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DSETUP,
    S_DACCESS,
    S_RESP
  } state_t;

  state_t                  state_q,     state_d;
  logic [15:0]             cnt_q,       cnt_d;
  slot_t                   slot_q,      slot_d;
  sel_t                    m_psel_q,    m_psel_d;
  logic                    m_penable_q, m_penable_d;
  logic                    m_pwrite_q,  m_pwrite_d;
  logic [ADDR_WIDTH-1:0]   m_paddr_q,   m_paddr_d;
  logic [DATA_WIDTH-1:0]   m_pwdata_q,  m_pwdata_d;
  logic [STRB_W-1:0]       m_pstrb_q,   m_pstrb_d;
  logic [DATA_WIDTH-1:0]   s_prdata_q,  s_prdata_d;
  logic                    s_pready_q,  s_pready_d;
  logic                    s_pslverr_q, s_pslverr_d;

  // Address decode of the live upstream request.
  addr_x_t off_x;
  logic    hit;
  slot_t   slot_dec;

  assign off_x    = {1'b0, s_paddr} - START_X;
  assign hit      = ({1'b0, s_paddr} >= START_X) && (off_x < SPAN_X);
  assign slot_dec = slot_t'(off_x >> INC_LOG2);

  // Response of the latched slot only; every other slot's bus is ignored.
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;

  assign sel_ready = m_pready[slot_q];
  assign sel_err   = m_pslverr[slot_q];
  assign sel_rdata = m_prdata[slot_q*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    m_psel_d    = m_psel_q;
    m_penable_d = m_penable_q;
    m_pwrite_d  = m_pwrite_q;
    m_paddr_d   = m_paddr_q;
    m_pwdata_d  = m_pwdata_q;
    m_pstrb_d   = m_pstrb_q;
    // Upstream response is a single-cycle pulse, zero otherwise.
    s_prdata_d  = '0;
    s_pready_d  = 1'b0;
    s_pslverr_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (s_psel && !s_penable) begin
          m_pwrite_d = s_pwrite;
          m_paddr_d  = s_paddr & OFFS_MASK;
          m_pwdata_d = s_pwdata;
          m_pstrb_d  = s_pstrb;
          slot_d     = slot_dec;
          cnt_d      = '0;
          if (hit) begin
            m_psel_d    = sel_t'(1) << slot_dec;
            m_penable_d = 1'b0;
            state_d     = S_DSETUP;
          end else begin
            s_pready_d  = 1'b1;
            s_pslverr_d = 1'b1;
            state_d     = S_RESP;
          end
        end
      end

      S_DSETUP: begin
        m_penable_d = 1'b1;
        state_d     = S_DACCESS;
      end

      S_DACCESS: begin
        if (sel_ready) begin
          m_psel_d    = '0;
          m_penable_d = 1'b0;
          s_pready_d  = 1'b1;
          s_prdata_d  = sel_rdata;
          s_pslverr_d = sel_err;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
          // Last allowed unready cycle: abort with an error, no read data.
          if (cnt_q == TO_LAST) begin
            m_psel_d    = '0;
            m_penable_d = 1'b0;
            s_pready_d  = 1'b1;
            s_pslverr_d = 1'b1;
            state_d     = S_RESP;
          end
        end
      end

      S_RESP: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      slot_q      <= '0;
      m_psel_q    <= '0;
      m_penable_q <= 1'b0;
      m_pwrite_q  <= 1'b0;
      m_paddr_q   <= '0;
      m_pwdata_q  <= '0;
      m_pstrb_q   <= '0;
      s_prdata_q  <= '0;
      s_pready_q  <= 1'b0;
      s_pslverr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      m_psel_q    <= m_psel_d;
      m_penable_q <= m_penable_d;
      m_pwrite_q  <= m_pwrite_d;
      m_paddr_q   <= m_paddr_d;
      m_pwdata_q  <= m_pwdata_d;
      m_pstrb_q   <= m_pstrb_d;
      s_prdata_q  <= s_prdata_d;
      s_pready_q  <= s_pready_d;
      s_pslverr_q <= s_pslverr_d;
    end
  end

  assign s_prdata  = s_prdata_q;
  assign s_pready  = s_pready_q;
  assign s_pslverr = s_pslverr_q;
  assign m_psel    = m_psel_q;
  assign m_penable = m_penable_q;
  assign m_pwrite  = m_pwrite_q;
  assign m_paddr   = m_paddr_q;
  assign m_pwdata  = m_pwdata_q;
  assign m_pstrb   = m_pstrb_q;

endmodule

// File: tb/tb_adam_lspa_apb_demux.sv
// ---------------------------------------------------------------------------
// Testbench for adam_lspa_apb_demux: an upstream APB driver pushes the
// expected response of every transfer into a queue; a monitor on the falling
// edge tracks the downstream side and pops/compares on each s_pready pulse.
// Downstream slots are emulated with a configurable wait count, read data and
// error; unselected slots drive ready=1 / pslverr=1 / random data.
// ---------------------------------------------------------------------------
module tb_adam_lspa_apb_demux;

  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          NS    = 4;
  localparam int          TO    = 255;
  localparam logic [31:0] START = 32'h0001_0000;
  localparam logic [31:0] INC   = 32'h0000_0400;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_psel, s_penable, s_pwrite;
  logic [AW-1:0]    s_paddr;
  logic [DW-1:0]    s_pwdata;
  logic [DW/8-1:0]  s_pstrb;
  logic [DW-1:0]    s_prdata;
  logic             s_pready, s_pslverr;
  logic [NS-1:0]    m_psel;
  logic             m_penable, m_pwrite;
  logic [AW-1:0]    m_paddr;
  logic [DW-1:0]    m_pwdata;
  logic [DW/8-1:0]  m_pstrb;
  logic [NS*DW-1:0] m_prdata;
  logic [NS-1:0]    m_pready;
  logic [NS-1:0]    m_pslverr;

  always #5 clk = ~clk;

  adam_lspa_apb_demux #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NO_SLOTS(NS),
    .MMAP_START(START), .MMAP_INC(INC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
    .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
    .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- expected-response scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    logic [3:0]  sel;
    int          nsel;
    int          nen;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pwrite;
    longint      ts;
  } exp_t;

  exp_t q[$];

  // Reference model: what the window map and slot behaviour say should happen.
  function automatic exp_t model(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb,
                                 input int wt, input logic [31:0] rd,
                                 input logic er, input logic never);
    exp_t   e;
    longint a    = longint'(addr);
    longint base = longint'(START);
    longint span = longint'(NS) * longint'(INC);
    int     s;
    e.pwrite = wr;
    e.pwdata = wdata;
    e.pstrb  = strb;
    e.paddr  = 32'(a % longint'(INC));
    e.ts     = 0;
    if (a < base || a >= base + span) begin
      e.sel = 4'b0; e.data = 32'h0; e.err = 1'b1;
      e.lat = 1; e.nsel = 0; e.nen = 0;
    end else begin
      s     = int'((a - base) / longint'(INC));
      e.sel = 4'(1 << s);
      if (never) begin
        e.data = 32'h0; e.err = 1'b1;
        e.lat = 2 + TO; e.nsel = 1 + TO; e.nen = TO;
      end else begin
        e.data = rd; e.err = er;
        e.lat = 3 + wt; e.nsel = wt + 2; e.nen = wt + 1;
      end
    end
    return e;
  endfunction

  // ---------------- downstream slot emulation ----------------
  int          cfg_wait  = 0;
  logic [31:0] cfg_rdata = 32'h0;
  logic        cfg_err   = 1'b0;
  logic        cfg_never = 1'b0;
  int          acc_cnt   = 0;

  initial begin
    m_pready  = '1;
    m_pslverr = '1;
    m_prdata  = '0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (m_psel[i] && m_penable) begin
        m_pready[i]            <= !cfg_never && (acc_cnt == cfg_wait);
        m_prdata[i*DW +: DW]   <= cfg_rdata;
        m_pslverr[i]           <= cfg_err;
      end else begin
        m_pready[i]            <= 1'b1;
        m_prdata[i*DW +: DW]   <= $urandom;
        m_pslverr[i]           <= 1'b1;
      end
    end
    acc_cnt <= m_penable ? acc_cnt + 1 : 0;
  end

  // ---------------- monitor ----------------
  int          n_sel = 0, n_en = 0;
  logic        sel_bad = 1'b0, idle_bad = 1'b0;
  logic [31:0] o_paddr = 0, o_pwdata = 0;
  logic [3:0]  o_pstrb = 0;
  logic        o_pwrite = 0;

  initial begin
    exp_t e;
    int   lat;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        n_sel = 0; n_en = 0; sel_bad = 1'b0; idle_bad = 1'b0;
      end else begin
        if (m_psel != '0) begin
          n_sel++;
          if (q.size() == 0 || m_psel != q[0].sel) sel_bad = 1'b1;
          if (!m_penable) begin
            o_paddr = m_paddr; o_pwdata = m_pwdata;
            o_pstrb = m_pstrb; o_pwrite = m_pwrite;
          end
        end
        if (m_penable) begin
          n_en++;
          if (m_psel == '0) sel_bad = 1'b1;
        end
        if (!s_pready && (s_prdata != '0 || s_pslverr)) idle_bad = 1'b1;
        if (s_pready) begin
          if (q.size() == 0) begin
            chk("unexpected_resp", 1, 0);
          end else begin
            e   = q.pop_front();
            lat = int'(($time - e.ts - 4) / 10);
            chk("prdata", s_prdata, e.data);
            chk("pslverr", s_pslverr, e.err);
            chk("latency", lat, e.lat);
            chk("psel_cycles", n_sel, e.nsel);
            chk("penable_cycles", n_en, e.nen);
            chk("psel_isolation", sel_bad, 0);
            chk("resp_zero_outside_resp", idle_bad, 0);
            if (e.sel != 0) begin
              chk("m_paddr", o_paddr, e.paddr);
              chk("m_pwdata", o_pwdata, e.pwdata);
              chk("m_pstrb", o_pstrb, e.pstrb);
              chk("m_pwrite", o_pwrite, e.pwrite);
            end
          end
          n_sel = 0; n_en = 0; sel_bad = 1'b0; idle_bad = 1'b0;
        end
      end
    end
  end

  // ---------------- upstream driver ----------------
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int wt, input logic [31:0] rd,
                      input logic er, input logic never, input logic abuse);
    exp_t e;
    int   n;
    logic got;
    @(posedge clk); #1;
    cfg_wait = wt; cfg_rdata = rd; cfg_err = er; cfg_never = never;
    s_psel = 1'b1; s_penable = 1'b0; s_pwrite = wr;
    s_paddr = addr; s_pwdata = wdata; s_pstrb = strb;
    e    = model(wr, addr, wdata, strb, wt, rd, er, never);
    e.ts = longint'($time);
    q.push_back(e);
    @(posedge clk); #1;
    if (abuse) begin
      s_psel = 1'b0; s_penable = 1'b0;
    end else begin
      s_penable = 1'b1;
    end
    n = 0; got = 1'b0;
    while (!got && n < 600) begin
      @(negedge clk);
      if (s_pready) got = 1'b1;
      n++;
    end
    if (!got) chk("resp_wait_expired", 0, 1);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    s_psel = 1'b0; s_penable = 1'b0;
    if (n > 1) repeat (n - 1) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          r;
    s_psel = 0; s_penable = 0; s_pwrite = 0; s_paddr = 0; s_pwdata = 0; s_pstrb = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_zero",
        |{s_prdata, s_pready, s_pslverr, m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // write hit, zero wait
    xfer(1'b1, 32'h0001_0404, 32'hA5A5_0001, 4'hF, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(2);
    // read hit with 5 wait cycles on slot 3
    xfer(1'b0, 32'h0001_0C10, 32'h0, 4'h0, 5, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    idle(1);
    // decode misses at both window edges, back to back
    xfer(1'b0, 32'h0001_1000, 32'h0, 4'h0, 0, 32'h5555_5555, 1'b0, 1'b0, 1'b0);
    xfer(1'b0, 32'h0000_FFFC, 32'h0, 4'h0, 0, 32'h5555_5555, 1'b0, 1'b0, 1'b0);
    idle(1);
    // timeout on slot 0, then a normal transfer right after
    xfer(1'b0, 32'h0001_0000, 32'h0, 4'h0, 0, 32'h7777_7777, 1'b0, 1'b1, 1'b0);
    xfer(1'b0, 32'h0001_0008, 32'h0, 4'h0, 1, 32'h0000_BEEF, 1'b0, 1'b0, 1'b0);
    idle(1);
    // downstream error on slot 2 while other slots present garbage
    xfer(1'b0, 32'h0001_0800, 32'h0, 4'h0, 0, 32'h0000_CAFE, 1'b1, 1'b0, 1'b0);
    idle(1);
    // last word of the window and upstream dropping psel mid-transfer
    xfer(1'b1, 32'h0001_0FFC, 32'hDEAD_0003, 4'h5, 2, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(1);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r < 7)
        a = START + INC * $urandom_range(0, 3) + ($urandom_range(0, 255) << 2);
      else if (r == 7)
        a = $urandom_range(0, 32'h0000_FFFF) & 32'hFFFF_FFFC;
      else
        a = START + 4 * INC + ($urandom & 32'h00FF_FFFC);
      xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 6), $urandom, $urandom_range(0, 3) == 0, 1'b0,
           $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);

    // reset in the middle of a downstream access
    cfg_never = 1'b1;
    @(posedge clk); #1;
    s_psel = 1'b1; s_penable = 1'b0; s_pwrite = 1'b0; s_paddr = 32'h0001_0000;
    @(posedge clk); #1;
    s_penable = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_reset_in_access", {m_penable, m_psel}, 5'b1_0001);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs_zero",
        |{s_prdata, s_pready, s_pslverr, m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb}, 0);
    s_psel = 1'b0; s_penable = 1'b0; cfg_never = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    xfer(1'b0, 32'h0001_0420, 32'h0, 4'h0, 1, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
